// File: rtl/vip_pkg.sv
// ---------------------------------------------------------------------------
// vip_pkg: shared definitions for the vip video-processing stages.
//   COORD_W      pixel coordinate width
//   RGB_*        RGB565 colour constants
//   ST_*         edge-statistics FSM state encodings
//   bbox_t       bounding-box payload (x_min, x_max, y_min, y_max)
//   bbox_init()  accumulator start value (empty box)
// ---------------------------------------------------------------------------
package vip_pkg;

   localparam int unsigned COORD_W = 11;
   localparam int unsigned RGB_W   = 16;

   localparam logic [RGB_W-1:0] RGB_WHITE = 16'hFFFF;
   localparam logic [RGB_W-1:0] RGB_BLACK = 16'h0000;
   localparam logic [RGB_W-1:0] RGB_RED   = 16'hF800;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACTIVE  = 2'd1;
   localparam logic [1:0] ST_PUBLISH = 2'd2;

   typedef struct packed {
      logic [COORD_W-1:0] x_min;
      logic [COORD_W-1:0] x_max;
      logic [COORD_W-1:0] y_min;
      logic [COORD_W-1:0] y_max;
   } bbox_t;

   // Empty box: mins at all-ones and maxes at zero so the first hit overwrites both.
   function automatic bbox_t bbox_init();
      bbox_t b;
      b.x_min = '1;
      b.x_max = '0;
      b.y_min = '1;
      b.y_max = '0;
      return b;
   endfunction

endpackage

// File: rtl/vip_pix_coord.sv
// ---------------------------------------------------------------------------
// vip_pix_coord: pixel coordinate generator shared by vip stages.
//   clk, rst       clock, asynchronous active-high reset
//   vsync, href,   input sync / pixel-valid signals
//   clken
//   x_cnt, y_cnt   coordinate of the pixel presented this cycle
//   vsync_rise_c   combinational frame-boundary strobe (vsync rising edge)
// x_cnt saturates at IMG_W and clears when href falls; y_cnt counts lines
// that carried at least one pixel, saturates at IMG_H, clears on vsync rise.
// ---------------------------------------------------------------------------
module vip_pix_coord
   import vip_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vsync,
   input  logic               href,
   input  logic               clken,
   output logic [COORD_W-1:0] x_cnt,
   output logic [COORD_W-1:0] y_cnt,
   output logic               vsync_rise_c
);

   logic               vsync_q, vsync_d;
   logic               href_q, href_d;
   logic               line_pix_q, line_pix_d;
   logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
   logic [COORD_W-1:0] y_cnt_q, y_cnt_d;
   logic               href_fall_c;

   // Edge strobes and counter next-state.
   always_comb begin
      vsync_rise_c = vsync & ~vsync_q;
      href_fall_c  = ~href & href_q;
      vsync_d      = vsync;
      href_d       = href;
      x_cnt_d      = x_cnt_q;
      y_cnt_d      = y_cnt_q;
      line_pix_d   = line_pix_q;

      if (href && clken) begin
         line_pix_d = 1'b1;
         if (x_cnt_q < COORD_W'(IMG_W)) begin
            x_cnt_d = x_cnt_q + COORD_W'(1);
         end
      end

      if (href_fall_c) begin
         x_cnt_d    = '0;
         line_pix_d = 1'b0;
         if (line_pix_q && (y_cnt_q < COORD_W'(IMG_H))) begin
            y_cnt_d = y_cnt_q + COORD_W'(1);
         end
      end

      // Frame boundary wins over a coincident line end.
      if (vsync_rise_c) begin
         y_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         line_pix_q <= 1'b0;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
      end else begin
         vsync_q    <= vsync_d;
         href_q     <= href_d;
         line_pix_q <= line_pix_d;
         x_cnt_q    <= x_cnt_d;
         y_cnt_q    <= y_cnt_d;
      end
   end

   assign x_cnt = x_cnt_q;
   assign y_cnt = y_cnt_q;

endmodule

// File: rtl/vip_edge_bbox.sv
// ---------------------------------------------------------------------------
// vip_edge_bbox: per-frame edge statistics for the Sobel edge stream.
// Counts edge pixels and tracks their bounding box; at every frame boundary
// the results are published with a one-cycle frame_done pulse. The stream is
// re-emitted one cycle later as RGB565 (edge = black, background = white).
//   clk, rst                     clock, asynchronous active-high reset
//   per_frame_vsync/href/clken   input sync and pixel valid
//   per_img_bit                  1 = edge pixel
//   post_frame_vsync/hsync/de    sync delayed one cycle
//   post_rgb                     display pixel
//   bbox_x_min/x_max/y_min/y_max last frame's box (0 when no edges)
//   edge_cnt                     last frame's edge count (saturating)
//   bbox_valid                   edge_cnt >= MIN_PIXELS
//   frame_done                   one-cycle pulse when results update
// Build option VIP_BBOX_OVERLAY_EN: draws the published box perimeter in red
// on post_rgb while bbox_valid is set.
// ---------------------------------------------------------------------------
module vip_edge_bbox
   import vip_pkg::*;
#(
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480,
   parameter int unsigned MIN_PIXELS = 64,
   parameter int unsigned CNT_W      = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               per_frame_vsync,
   input  logic               per_frame_href,
   input  logic               per_frame_clken,
   input  logic               per_img_bit,
   output logic               post_frame_vsync,
   output logic               post_frame_hsync,
   output logic               post_frame_de,
   output logic [RGB_W-1:0]   post_rgb,
   output logic [COORD_W-1:0] bbox_x_min,
   output logic [COORD_W-1:0] bbox_x_max,
   output logic [COORD_W-1:0] bbox_y_min,
   output logic [COORD_W-1:0] bbox_y_max,
   output logic [CNT_W-1:0]   edge_cnt,
   output logic               bbox_valid,
   output logic               frame_done
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [COORD_W-1:0] x_cnt, y_cnt;
   logic               vsync_rise_c;
   logic               hit_c;

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
   bbox_t              acc_box_q, acc_box_d;
   bbox_t              pub_box_q, pub_box_d;
   logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic               bbox_valid_q, bbox_valid_d;
   logic               frame_done_q, frame_done_d;
   logic               post_vsync_q, post_vsync_d;
   logic               post_hsync_q, post_hsync_d;
   logic               post_de_q, post_de_d;
   logic [RGB_W-1:0]   post_rgb_q, post_rgb_d;

   vip_pix_coord #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_coord (
      .clk          (clk),
      .rst          (rst),
      .vsync        (per_frame_vsync),
      .href         (per_frame_href),
      .clken        (per_frame_clken),
      .x_cnt        (x_cnt),
      .y_cnt        (y_cnt),
      .vsync_rise_c (vsync_rise_c)
   );

   assign hit_c = per_frame_href & per_frame_clken & per_img_bit &
                  (x_cnt < COORD_W'(IMG_W)) & (y_cnt < COORD_W'(IMG_H));

`ifdef VIP_BBOX_OVERLAY_EN
   // Perimeter test on the current pixel's own coordinates; the red pixel is
   // registered together with the video, so latency stays at one cycle.
   logic on_col_c, on_row_c;
   always_comb begin
      on_col_c = ((x_cnt == pub_box_q.x_min) || (x_cnt == pub_box_q.x_max)) &&
                 (y_cnt >= pub_box_q.y_min) && (y_cnt <= pub_box_q.y_max);
      on_row_c = ((y_cnt == pub_box_q.y_min) || (y_cnt == pub_box_q.y_max)) &&
                 (x_cnt >= pub_box_q.x_min) && (x_cnt <= pub_box_q.x_max);
   end
`endif

   // FSM, accumulators, publish and video path next-state.
   always_comb begin
      state_d      = state_q;
      acc_cnt_d    = acc_cnt_q;
      acc_box_d    = acc_box_q;
      pub_box_d    = pub_box_q;
      edge_cnt_d   = edge_cnt_q;
      bbox_valid_d = bbox_valid_q;
      frame_done_d = 1'b0;
      post_vsync_d = per_frame_vsync;
      post_hsync_d = per_frame_href;
      post_de_d    = per_frame_clken;
      post_rgb_d   = per_img_bit ? RGB_BLACK : RGB_WHITE;

      case (state_q)
         ST_IDLE: begin
            // Partial frame after reset is never accumulated.
            acc_cnt_d = '0;
            acc_box_d = bbox_init();
            if (vsync_rise_c) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (vsync_rise_c) state_d = ST_PUBLISH;
         end
         ST_PUBLISH: begin
            frame_done_d = 1'b1;
            edge_cnt_d   = acc_cnt_q;
            bbox_valid_d = (acc_cnt_q >= CNT_W'(MIN_PIXELS));
            pub_box_d    = (acc_cnt_q == '0) ? '0 : acc_box_q;
            acc_cnt_d    = '0;
            acc_box_d    = bbox_init();
            state_d      = ST_ACTIVE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Applied after the PUBLISH re-init so a pixel in that cycle opens the new frame.
      if (hit_c && (state_q != ST_IDLE)) begin
         if (acc_cnt_d != CNT_MAX) acc_cnt_d = acc_cnt_d + CNT_W'(1);
         if (x_cnt < acc_box_d.x_min) acc_box_d.x_min = x_cnt;
         if (x_cnt > acc_box_d.x_max) acc_box_d.x_max = x_cnt;
         if (y_cnt < acc_box_d.y_min) acc_box_d.y_min = y_cnt;
         if (y_cnt > acc_box_d.y_max) acc_box_d.y_max = y_cnt;
      end

`ifdef VIP_BBOX_OVERLAY_EN
      if (per_frame_href && per_frame_clken && bbox_valid_q && (on_col_c || on_row_c)) begin
         post_rgb_d = RGB_RED;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         acc_cnt_q    <= '0;
         acc_box_q    <= bbox_init();
         pub_box_q    <= '0;
         edge_cnt_q   <= '0;
         bbox_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         post_vsync_q <= 1'b0;
         post_hsync_q <= 1'b0;
         post_de_q    <= 1'b0;
         post_rgb_q   <= '0;
      end else begin
         state_q      <= state_d;
         acc_cnt_q    <= acc_cnt_d;
         acc_box_q    <= acc_box_d;
         pub_box_q    <= pub_box_d;
         edge_cnt_q   <= edge_cnt_d;
         bbox_valid_q <= bbox_valid_d;
         frame_done_q <= frame_done_d;
         post_vsync_q <= post_vsync_d;
         post_hsync_q <= post_hsync_d;
         post_de_q    <= post_de_d;
         post_rgb_q   <= post_rgb_d;
      end
   end

   assign post_frame_vsync = post_vsync_q;
   assign post_frame_hsync = post_hsync_q;
   assign post_frame_de    = post_de_q;
   assign post_rgb         = post_rgb_q;
   assign bbox_x_min       = pub_box_q.x_min;
   assign bbox_x_max       = pub_box_q.x_max;
   assign bbox_y_min       = pub_box_q.y_min;
   assign bbox_y_max       = pub_box_q.y_max;
   assign edge_cnt         = edge_cnt_q;
   assign bbox_valid       = bbox_valid_q;
   assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_vip_edge_bbox.sv
// ---------------------------------------------------------------------------
// tb_vip_edge_bbox: stimulus drives frames of edge pixels; at each closing
// vsync the expected statistics of the frame are queued, and a negedge
// monitor checks every published result, the one-cycle video path, and that
// published values hold between pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vip_edge_bbox;

   localparam int IMG_W      = 640;
   localparam int IMG_H      = 480;
   localparam int MIN_PIXELS = 64;
   localparam int CNT_W      = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic              per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit;
   logic              post_frame_vsync, post_frame_hsync, post_frame_de;
   logic [15:0]       post_rgb;
   logic [10:0]       bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
   logic [CNT_W-1:0]  edge_cnt;
   logic              bbox_valid, frame_done;

   vip_edge_bbox #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .MIN_PIXELS(MIN_PIXELS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
      .per_frame_clken(per_frame_clken), .per_img_bit(per_img_bit),
      .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
      .post_frame_de(post_frame_de), .post_rgb(post_rgb),
      .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
      .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
      .edge_cnt(edge_cnt), .bbox_valid(bbox_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int xmin, xmax, ymin, ymax;
      bit valid;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   // Frame model state
   bit   armed = 1'b0;
   int   m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
   int   line_y = 0;
   int   drv_x = -1, drv_y = -1;

   // Stimulus shape: mode 0 = rectangle, mode 1 = random density
   int   mode = 0, rx0 = 0, rx1 = 0, ry0 = 0, ry1 = 0, density = 0, gap_pct = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

`ifdef VIP_BBOX_OVERLAY_EN
   function automatic bit on_perim(input int x, input int y, input exp_t b);
      return (((x == b.xmin) || (x == b.xmax)) && (y >= b.ymin) && (y <= b.ymax)) ||
             (((y == b.ymin) || (y == b.ymax)) && (x >= b.xmin) && (x <= b.xmax));
   endfunction
`endif

   // ---------------- monitor / scoreboard ----------------
   bit   prev_rst = 1'b1;
   bit   p_vs = 0, p_hr = 0, p_ce = 0, p_b = 0;
   int   p_x = -1, p_y = -1;
   exp_t pub, p_pub;

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [15:0] exp_rgb;
      if (rst || prev_rst) begin
         chk("reset_outputs",
             {post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb, frame_done, bbox_valid, edge_cnt}, 0);
         chk("reset_box", {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}, 0);
         pub = '{default: 0};
      end else begin
         exp_rgb = p_b ? 16'h0000 : 16'hFFFF;
`ifdef VIP_BBOX_OVERLAY_EN
         if (p_ce && p_pub.valid && on_perim(p_x, p_y, p_pub)) exp_rgb = 16'hF800;
`endif
         chk("video", {post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb},
             {p_vs, p_hr, p_ce, exp_rgb});
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", frame_done, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_latency", cyc, e.due);
               chk("edge_cnt", edge_cnt, e.cnt);
               chk("bbox_x_min", bbox_x_min, e.xmin);
               chk("bbox_x_max", bbox_x_max, e.xmax);
               chk("bbox_y_min", bbox_y_min, e.ymin);
               chk("bbox_y_max", bbox_y_max, e.ymax);
               chk("bbox_valid", bbox_valid, e.valid);
               pub = e;
            end
         end else begin
            chk("hold_box", {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max},
                {11'(pub.xmin), 11'(pub.xmax), 11'(pub.ymin), 11'(pub.ymax)});
            chk("hold_stat", {edge_cnt, bbox_valid}, {CNT_W'(pub.cnt), pub.valid});
         end
      end
      p_vs     = per_frame_vsync;
      p_hr     = per_frame_href;
      p_ce     = per_frame_clken;
      p_b      = per_img_bit;
      p_x      = drv_x;
      p_y      = drv_y;
      p_pub    = pub;
      prev_rst = rst;
   end

   // ---------------- driver ----------------
   task automatic drive(input bit vs, input bit hr, input bit ce, input bit b,
                        input int x, input int y);
      @(posedge clk);
      #1;
      per_frame_vsync = vs;
      per_frame_href  = hr;
      per_frame_clken = ce;
      per_img_bit     = b;
      drv_x           = x;
      drv_y           = y;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0, -1, -1);
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_xmin = 1 << 30;
      m_xmax = -1;
      m_ymin = 1 << 30;
      m_ymax = -1;
   endtask

   // Frame boundary: closes the current frame (if one was being tracked) and opens the next.
   task automatic send_vsync(input int len);
      exp_t e;
      drive(1, 0, 0, 0, -1, -1);
      if (armed) begin
         e.cnt   = m_cnt;
         e.valid = (m_cnt >= MIN_PIXELS);
         e.xmin  = (m_cnt == 0) ? 0 : m_xmin;
         e.xmax  = (m_cnt == 0) ? 0 : m_xmax;
         e.ymin  = (m_cnt == 0) ? 0 : m_ymin;
         e.ymax  = (m_cnt == 0) ? 0 : m_ymax;
         e.due   = cyc + 2;
         exp_q.push_back(e);
      end
      armed  = 1'b1;
      line_y = 0;
      model_reset();
      repeat (len - 1) drive(1, 0, 0, 0, -1, -1);
      idle(3);
   endtask

   task automatic send_line(input int w);
      bit b;
      for (int x = 0; x < w; x++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct)
            repeat ($urandom_range(1, 3)) drive(0, 1, 0, 0, -1, -1);
         if (mode == 0) b = (x >= rx0) && (x <= rx1) && (line_y >= ry0) && (line_y <= ry1);
         else           b = ($urandom_range(99) < density);
         drive(0, 1, 1, b, x, line_y);
         if (b && x < IMG_W && line_y < IMG_H) begin
            m_cnt++;
            if (x < m_xmin) m_xmin = x;
            if (x > m_xmax) m_xmax = x;
            if (line_y < m_ymin) m_ymin = line_y;
            if (line_y > m_ymax) m_ymax = line_y;
         end
      end
      idle(2);
      line_y++;
   endtask

   task automatic send_frame(input int w, input int h);
      for (int y = 0; y < h; y++) send_line(w);
   endtask

   task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
      mode = 0; rx0 = x0; rx1 = x1; ry0 = y0; ry1 = y1;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst = 1'b1;
      armed = 1'b0;
      per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0; per_img_bit = 0;
      drv_x = -1; drv_y = -1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0; per_img_bit = 0;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;

      // Lines before any vsync: never published.
      set_rect(0, 20, 0, 3);
      send_frame(30, 4);
      send_vsync(3);
      // Frame interrupted by a 5-cycle reset; the remainder is a discarded partial frame.
      send_frame(40, 3);
      do_reset(5);
      send_frame(40, 3);
      send_vsync(3);

      // 10x10 block, then published under a long vsync (single publish).
      set_rect(100, 109, 50, 59);
      send_frame(120, 62);
      send_vsync(20);

      // Below threshold; this frame also shows the overlay of the block.
      set_rect(5, 12, 5, 5);
      send_frame(112, 62);
      send_vsync(3);

      // Empty frame.
      set_rect(1, 0, 0, 0);
      send_frame(30, 5);
      send_vsync(3);

      // Edges only beyond IMG_W.
      set_rect(650, 699, 0, 1);
      send_frame(700, 2);
      send_vsync(3);

      // Edges on lines beyond IMG_H are ignored.
      set_rect(0, 1, 0, 1000);
      send_frame(2, 490);
      send_vsync(3);

      // Random frames with clken gaps.
      mode    = 1;
      gap_pct = 15;
      repeat (5) begin
         density = $urandom_range(0, 100);
         send_frame($urandom_range(8, 60), $urandom_range(3, 20));
         send_vsync($urandom_range(2, 6));
      end

      set_rect(3, 30, 2, 9);
      send_frame(40, 12);
      send_vsync(3);

      idle(10);
      chk("pending_results", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
